// File: rtl/flu_rr_arbiter.sv
// Packet-granular round-robin merge of PORTS FLU streams onto one FLU output.
// Zero-cycle latency (pure mux); TX_DST_RDY is steered only to the granted input, all others see 0.
module flu_rr_arbiter #(
    parameter int PORTS         = 2,
    parameter int DATA_WIDTH    = 256,
    parameter int SOP_POS_WIDTH = 2,
    parameter int EOP_POS_WIDTH = 5,
    localparam int CHW          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [PORTS*DATA_WIDTH-1:0]      RX_DATA,
    input  logic [PORTS*SOP_POS_WIDTH-1:0]   RX_SOP_POS,
    input  logic [PORTS*EOP_POS_WIDTH-1:0]   RX_EOP_POS,
    input  logic [PORTS-1:0]                 RX_SOP,
    input  logic [PORTS-1:0]                 RX_EOP,
    input  logic [PORTS-1:0]                 RX_SRC_RDY,
    output logic [PORTS-1:0]                 RX_DST_RDY,
    output logic [DATA_WIDTH-1:0]            TX_DATA,
    output logic [SOP_POS_WIDTH-1:0]         TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0]         TX_EOP_POS,
    output logic                             TX_SOP,
    output logic                             TX_EOP,
    output logic                             TX_SRC_RDY,
    input  logic                             TX_DST_RDY,
    output logic [CHW-1:0]                   TX_CHANNEL
);

    logic                     lock;
    logic [CHW-1:0]           sel;
    logic [CHW-1:0]           ptr;

    logic                     gnt_vld;
    logic [CHW-1:0]           gnt;
    logic                     xfer;
    logic                     lock_nxt;
    logic [EOP_POS_WIDTH-1:0] sop_byte;

    // Search runs highest offset first so the nearest requester after ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt     = sel;
        if (lock) begin
            gnt_vld = 1'b1;
            gnt     = sel;
        end else begin
            for (int k = PORTS; k >= 1; k--) begin
                idx = (int'(ptr) + k) % PORTS;
                if (RX_SRC_RDY[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = CHW'(idx);
                end
            end
        end
    end

    always_comb begin
        TX_DATA    = RX_DATA[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        TX_SOP_POS = RX_SOP_POS[int'(gnt)*SOP_POS_WIDTH +: SOP_POS_WIDTH];
        TX_EOP_POS = RX_EOP_POS[int'(gnt)*EOP_POS_WIDTH +: EOP_POS_WIDTH];
        TX_SOP     = RX_SOP[gnt];
        TX_EOP     = RX_EOP[gnt];
        TX_CHANNEL = gnt;
        TX_SRC_RDY = !RESET && gnt_vld && RX_SRC_RDY[gnt];
        RX_DST_RDY = (!RESET && gnt_vld && TX_DST_RDY) ? (PORTS'(1) << gnt) : '0;
    end

    assign xfer     = TX_SRC_RDY && TX_DST_RDY;
    assign sop_byte = EOP_POS_WIDTH'(TX_SOP_POS) << (EOP_POS_WIDTH - SOP_POS_WIDTH);

    // A word that closes one packet and opens another keeps the lock on the same input.
    always_comb begin
        lock_nxt = lock;
        case ({TX_SOP, TX_EOP})
            2'b10:   lock_nxt = 1'b1;
            2'b01:   lock_nxt = 1'b0;
            2'b11:   lock_nxt = (sop_byte > TX_EOP_POS);
            default: lock_nxt = lock;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock <= 1'b0;
            sel  <= '0;
            ptr  <= CHW'(PORTS - 1);
        end else if (xfer) begin
            lock <= lock_nxt;
            if (!lock) begin
                ptr <= gnt;
                sel <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_flu_rr_arbiter.sv
// Randomised and directed checks of flu_rr_arbiter (PORTS=4) against a packet-level arbitration model.
module tb_flu_rr_arbiter;
    localparam int P  = 4;
    localparam int DW = 256;
    localparam int SW = 2;
    localparam int EW = 5;
    localparam int CW = 2;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [P*DW-1:0]  RX_DATA = '0;
    logic [P*SW-1:0]  RX_SOP_POS = '0;
    logic [P*EW-1:0]  RX_EOP_POS = '0;
    logic [P-1:0]     RX_SOP = '0;
    logic [P-1:0]     RX_EOP = '0;
    logic [P-1:0]     RX_SRC_RDY = '0;
    logic [P-1:0]     RX_DST_RDY;
    logic [DW-1:0]    TX_DATA;
    logic [SW-1:0]    TX_SOP_POS;
    logic [EW-1:0]    TX_EOP_POS;
    logic             TX_SOP;
    logic             TX_EOP;
    logic             TX_SRC_RDY;
    logic             TX_DST_RDY = 1'b0;
    logic [CW-1:0]    TX_CHANNEL;

    flu_rr_arbiter #(
        .PORTS(P), .DATA_WIDTH(DW), .SOP_POS_WIDTH(SW), .EOP_POS_WIDTH(EW)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
        .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
        .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
        .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
        .TX_CHANNEL(TX_CHANNEL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] sp;
        logic [EW-1:0] ep;
        logic          sop;
        logic          eop;
    } word_t;

    word_t       q[P][$];
    logic [P-1:0] en = '1;
    logic        dst_en = 1'b1;
    logic        rst_v = 1'b1;

    // Arbitration model: who owns the output, and who was served last.
    int          lock_m = 0;
    int          sel_m  = 0;
    int          ptr_m  = P - 1;

    int          total  = 0;
    int          passed = 0;
    int          log_q[$];
    logic        cap_src;
    logic [P-1:0] cap_dst;
    logic [CW-1:0] cap_ch;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic word_t rnd_word();
        word_t w;
        for (int i = 0; i < DW/32; i++) w.d[i*32 +: 32] = $urandom;
        w.sp  = SW'($urandom);
        w.ep  = EW'($urandom);
        w.sop = 1'($urandom);
        w.eop = 1'($urandom);
        return w;
    endfunction

    function automatic word_t mk(input logic sop, input logic eop, input int sp, input int ep);
        word_t w;
        w     = rnd_word();
        w.sop = sop;
        w.eop = eop;
        w.sp  = SW'(sp);
        w.ep  = EW'(ep);
        return w;
    endfunction

    task automatic push_pkt(input int p, input int len);
        for (int i = 0; i < len; i++)
            q[p].push_back(mk(i == 0, i == len - 1, 0, 31));
    endtask

    task automatic cycle();
        word_t cur[P];
        bit    s[P];
        int    g;
        bit    exp_src;
        int    sb;
        @(posedge CLK);
        #1;
        RESET      = rst_v;
        TX_DST_RDY = dst_en;
        for (int p = 0; p < P; p++) begin
            if (q[p].size() > 0 && en[p]) begin
                cur[p] = q[p][0];
                s[p]   = 1'b1;
            end else begin
                cur[p] = rnd_word();
                s[p]   = 1'b0;
            end
            RX_DATA[p*DW +: DW]    = cur[p].d;
            RX_SOP_POS[p*SW +: SW] = cur[p].sp;
            RX_EOP_POS[p*EW +: EW] = cur[p].ep;
            RX_SOP[p]              = cur[p].sop;
            RX_EOP[p]              = cur[p].eop;
            RX_SRC_RDY[p]          = s[p];
        end
        #4;
        if (rst_v) begin
            chk("rst_tx_src_rdy", TX_SRC_RDY, 0);
            chk("rst_rx_dst_rdy", RX_DST_RDY, 0);
            lock_m = 0;
            ptr_m  = P - 1;
        end else begin
            g = -1;
            if (lock_m != 0) g = sel_m;
            else begin
                for (int k = 1; k <= P; k++) begin
                    if (s[(ptr_m + k) % P]) begin
                        g = (ptr_m + k) % P;
                        break;
                    end
                end
            end
            exp_src = (g >= 0) && s[g];
            chk("tx_src_rdy", TX_SRC_RDY, exp_src);
            chk("rx_dst_rdy", RX_DST_RDY, (g >= 0 && dst_en) ? (1 << g) : 0);
            if (exp_src) begin
                chk("tx_channel", TX_CHANNEL, g);
                chk("tx_data",    TX_DATA,    cur[g].d);
                chk("tx_sop",     TX_SOP,     cur[g].sop);
                chk("tx_eop",     TX_EOP,     cur[g].eop);
                chk("tx_sop_pos", TX_SOP_POS, cur[g].sp);
                chk("tx_eop_pos", TX_EOP_POS, cur[g].ep);
                if (dst_en) begin
                    sb = int'(cur[g].sp) * (1 << (EW - SW));
                    if (lock_m == 0) begin
                        ptr_m = g;
                        sel_m = g;
                    end
                    if (cur[g].sop && !cur[g].eop)      lock_m = 1;
                    else if (!cur[g].sop && cur[g].eop) lock_m = 0;
                    else if (cur[g].sop && cur[g].eop)  lock_m = (sb > int'(cur[g].ep)) ? 1 : 0;
                end
            end
        end
        cap_src = TX_SRC_RDY;
        cap_dst = RX_DST_RDY;
        cap_ch  = TX_CHANNEL;
        if (TX_SRC_RDY === 1'b1 && TX_DST_RDY === 1'b1) log_q.push_back(int'(TX_CHANNEL));
        for (int p = 0; p < P; p++)
            if (s[p] && RX_DST_RDY[p] === 1'b1) void'(q[p].pop_front());
    endtask

    // Transfer order as hex nibbles, oldest first.
    task automatic chk_log(input string name, input int n, input logic [DW-1:0] enc);
        logic [DW-1:0] e;
        e = '0;
        chk({name, "_len"}, log_q.size(), n);
        foreach (log_q[i]) e = (e << 4) | DW'(log_q[i]);
        chk(name, e, enc);
        log_q.delete();
    endtask

    initial begin
        rst_v = 1'b1;
        repeat (2) cycle();
        rst_v = 1'b0;
        log_q.delete();

        // Two ports, 3-word packets each: whole packets alternate.
        push_pkt(0, 3); push_pkt(0, 3);
        push_pkt(1, 3); push_pkt(1, 3);
        repeat (12) cycle();
        chk_log("alt_3word", 12, 'h000111000111);

        // Backpressure after word 2 of a port-0 packet with port 1 waiting.
        push_pkt(0, 3); push_pkt(1, 3);
        repeat (2) cycle();
        dst_en = 1'b0;
        repeat (5) begin
            cycle();
            chk("bp_rx_dst_rdy", cap_dst, 0);
            chk("bp_channel",    cap_ch,  0);
            chk("bp_src_rdy",    cap_src, 1);
        end
        dst_en = 1'b1;
        repeat (4) cycle();
        chk_log("backpressure", 6, 'h000111);

        // Only port 1 active: back-to-back 2-word packets.
        push_pkt(1, 2); push_pkt(1, 2); push_pkt(1, 2);
        repeat (6) begin
            cycle();
            chk("solo_src_rdy", cap_src, 1);
            chk("solo_channel", cap_ch,  1);
        end
        chk_log("solo", 6, 'h111111);

        // Shared end/start word (sop_byte 16 > eop 9) keeps port 0 locked.
        q[0].push_back(mk(1, 0, 0, 0));
        q[0].push_back(mk(1, 1, 2, 9));
        q[0].push_back(mk(0, 1, 0, 31));
        q[1].push_back(mk(1, 1, 0, 31));
        repeat (4) cycle();
        chk_log("shared_word", 4, 'h0001);

        // Single-word packets release the lock, including sop_byte == eop_pos.
        q[0].push_back(mk(1, 1, 0, 31));
        q[0].push_back(mk(1, 1, 3, 24));
        q[1].push_back(mk(1, 1, 0, 31));
        q[1].push_back(mk(1, 1, 0, 31));
        repeat (4) cycle();
        chk_log("single_word", 4, 'h0101);

        // Four ports of single-word packets, reset pulsed mid-sequence.
        rst_v = 1'b1; cycle(); rst_v = 1'b0;
        for (int p = 0; p < P; p++) repeat (6) q[p].push_back(mk(1, 1, 0, 31));
        repeat (6) cycle();
        chk_log("rr4", 6, 'h012301);
        rst_v = 1'b1;
        repeat (2) begin
            cycle();
            chk("mid_rst_src_rdy", cap_src, 0);
        end
        rst_v = 1'b0;
        repeat (4) cycle();
        chk_log("rr4_after_rst", 4, 'h0123);

        // Random traffic, gating, backpressure and occasional reset.
        repeat (3000) begin
            for (int p = 0; p < P; p++) begin
                while (q[p].size() < 3) q[p].push_back(rnd_word());
                en[p] = ($urandom % 4) != 0;
            end
            dst_en = ($urandom % 4) != 0;
            rst_v  = ($urandom % 256) == 0;
            cycle();
        end
        log_q.delete();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
